// File: rtl/mac_acc_drain.sv
// Frame accumulator, round/shift/saturate and output FIFO for the mac cascade tail.
// Define MAC_DRAIN_CONV_ROUND_EN for round-half-to-even instead of round-half-up.
module mac_acc_drain #(
  parameter int PW         = 48,
  parameter int LEN        = 8,
  parameter int SHIFT      = 15,
  parameter int OW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] pin,
  input  logic          pin_valid,
  output logic [OW-1:0] dout,
  output logic          dout_sat,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          ovf,
  input  logic          clr_ovf
);

  localparam int AW   = PW + $clog2(LEN) + 1;
  localparam int CW   = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] pin_ext;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] sum_q;
  logic                 sum_v;

  assign pin_ext  = {{(AW-PW){pin[PW-1]}}, pin};
  assign acc_next = (cnt == '0) ? pin_ext : acc + pin_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      sum_q <= '0;
      sum_v <= 1'b0;
    end else begin
      sum_v <= 1'b0;
      if (pin_valid) begin
        acc <= acc_next;
        if (cnt == LAST) begin
          cnt   <= '0;
          sum_q <= acc_next;
          sum_v <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // one extra bit so the rounding increment can never wrap
  logic signed [AW:0] r;

  if (SHIFT > 0) begin : g_rnd
    logic [SHIFT-1:0]     rem;
    logic [SHIFT-1:0]     half;
    logic signed [AW-1:0] quo;
    logic                 round_up;

    always_comb begin
      half           = '0;
      half[SHIFT-1]  = 1'b1;
      rem            = sum_q[SHIFT-1:0];
      quo            = sum_q >>> SHIFT;
`ifdef MAC_DRAIN_CONV_ROUND_EN
      round_up       = (rem > half) || ((rem == half) && quo[0]);
`else
      round_up       = (rem >= half);
`endif
      r = {quo[AW-1], quo} + {{AW{1'b0}}, round_up};
    end
  end else begin : g_nornd
    always_comb r = {sum_q[AW-1], sum_q};
  end

  logic          sat_hi;
  logic          sat_lo;
  logic [OW-1:0] omin;
  logic [OW-1:0] res;

  // in range exactly when every bit from the sign down to bit OW-1 agrees
  always_comb begin
    omin         = '0;
    omin[OW-1]   = 1'b1;
    sat_hi       = !r[AW] && (|r[AW-1:OW-1]);
    sat_lo       = r[AW] && !(&r[AW-1:OW-1]);
    res          = r[OW-1:0];
    if (sat_hi) res = ~omin;
    else if (sat_lo) res = omin;
  end

  logic [OW-1:0] r_d;
  logic          r_sat;
  logic          r_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d   <= '0;
      r_sat <= 1'b0;
      r_v   <= 1'b0;
    end else begin
      r_d   <= res;
      r_sat <= sat_hi || sat_lo;
      r_v   <= sum_v;
    end
  end

  logic [OW:0]   mem [FIFO_DEPTH];
  logic [PTRW:0] wr_ptr;
  logic [PTRW:0] rd_ptr;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  logic [OW:0]   head;

  assign full       = (wr_ptr[PTRW] != rd_ptr[PTRW]) &&
                      (wr_ptr[PTRW-1:0] == rd_ptr[PTRW-1:0]);
  assign dout_valid = (wr_ptr != rd_ptr);
  assign do_pop     = dout_valid && dout_ready;
  assign do_push    = r_v && (!full || do_pop);
  assign drop       = r_v && full && !do_pop;
  assign head       = mem[rd_ptr[PTRW-1:0]];
  assign dout       = head[OW-1:0];
  assign dout_sat   = head[OW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PTRW-1:0]] <= {r_sat, r_d};
        wr_ptr                <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_acc_drain.sv
// Scoreboard bench for mac_acc_drain with default parameters.
module tb_mac_acc_drain;
  localparam int PW = 48;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pin;
  logic          pin_valid;
  logic [OW-1:0] dout;
  logic          dout_sat;
  logic          dout_valid;
  logic          dout_ready;
  logic          ovf;
  logic          clr_ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    longint d;
    longint s;
  } exp_t;
  exp_t sbq[$];

  mac_acc_drain dut (
    .clk        (clk),
    .rst        (rst),
    .pin        (pin),
    .pin_valid  (pin_valid),
    .dout       (dout),
    .dout_sat   (dout_sat),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input longint sum);
    exp_t   e;
    longint q;
    longint rem;
    bit     up;
    q   = sum >>> 15;
    rem = sum - q * 32768;
`ifdef MAC_DRAIN_CONV_ROUND_EN
    up  = (rem > 16384) || ((rem == 16384) && ((q & 1) != 0));
`else
    up  = (rem >= 16384);
`endif
    q = q + (up ? 1 : 0);
    e.s = 0;
    if (q > 32767) begin
      e.d = 32767; e.s = 1;
    end else if (q < -32768) begin
      e.d = -32768; e.s = 1;
    end else begin
      e.d = q;
    end
    return e;
  endfunction

  // consumer side: a handshake seen at the negedge completes on the next posedge
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("dout", longint'($signed(dout)), e.d);
        chk("dout_sat", longint'(dout_sat), e.s);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sample(input longint v);
    pin       = v[PW-1:0];
    pin_valid = 1'b1;
    @(posedge clk); #1;
    pin_valid = 1'b0;
    pin       = '0;
  endtask

  task automatic push_exp(input longint d, input longint s);
    exp_t e;
    e.d = d;
    e.s = s;
    sbq.push_back(e);
  endtask

  task automatic frame(input longint v0, input longint vr);
    sample(v0);
    for (int i = 1; i < 8; i++) sample(vr);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && sbq.size() > 0; i++) @(negedge clk);
    idle(3);
    chk(tag, sbq.size(), 0);
  endtask

  initial begin
    longint vals[8];
    longint sum;
    rst        = 1'b1;
    pin        = '0;
    pin_valid  = 1'b0;
    dout_ready = 1'b0;
    clr_ovf    = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", longint'(dout), 0);
    chk("rst_sat", dout_sat, 0);
    chk("rst_ovf", ovf, 0);

    // basic sum with latency
    dout_ready = 1'b1;
    push_exp(8, 0);
    frame(32768, 32768);
    @(negedge clk);
    chk("lat_e0", dout_valid, 0);
    @(negedge clk);
    chk("lat_e1", dout_valid, 0);
    @(negedge clk);
    chk("lat_e2", dout_valid, 1);
    drain("drain_basic");

    // saturation
    push_exp(32767, 1);
    frame(longint'(1) << 30, longint'(1) << 30);
    push_exp(-32768, 1);
    frame(-(longint'(1) << 30), -(longint'(1) << 30));
    drain("drain_sat");

    // rounding ties
`ifdef MAC_DRAIN_CONV_ROUND_EN
    push_exp(0, 0);
`else
    push_exp(1, 0);
`endif
    frame(16384, 0);
    push_exp(2, 0);
    frame(49152, 0);
    push_exp(0, 0);
    frame(-16384, 0);
    drain("drain_round");

    // backpressure and overflow
    dout_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) push_exp(k, 0);
      frame(4096 * k, 4096 * k);
    end
    idle(3);
    chk("ovf_set", ovf, 1);
    chk("bp_valid", dout_valid, 1);
    chk("bp_hold", longint'($signed(dout)), 1);
    idle(2);
    chk("bp_hold2", longint'($signed(dout)), 1);
    dout_ready = 1'b1;
    drain("drain_bp");
    chk("ovf_sticky", ovf, 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("ovf_clr", ovf, 0);

    // full with simultaneous pop
    dout_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push_exp(k, 0);
      frame(4096 * k, 4096 * k);
    end
    idle(3);
    push_exp(5, 0);
    frame(4096 * 5, 4096 * 5);
    idle(1);
    dout_ready = 1'b1;
    idle(1);
    chk("fullpop_ovf", ovf, 0);
    drain("drain_fullpop");
    chk("fullpop_ovf_end", ovf, 0);

    // random gaps against the model
    for (int f = 0; f < 4; f++) begin
      sum = 0;
      for (int i = 0; i < 8; i++) begin
        vals[i] = longint'($signed({$urandom(), $urandom()})) >>> $urandom_range(30, 44);
        sum += vals[i];
      end
      push_exp(model(sum).d, model(sum).s);
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 3)) begin
          pin = {$urandom(), $urandom()};
          @(posedge clk); #1;
        end
        sample(vals[i]);
      end
    end
    drain("drain_gaps");

    // reset mid-frame
    for (int i = 0; i < 3; i++) sample(32768 * 5);
    rst = 1'b1;
    #2;
    chk("midrst_valid", dout_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(8, 0);
    frame(32768, 32768);
    drain("drain_rst");
    idle(5);
    chk("end_ovf", ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
